// File: rtl/tawas_regfile_if.sv
// Tawas register-file port bundle: AU read/write-back, load/store return,
// load issue and hazard-check signals. Clock and reset stay outside.
interface tawas_regfile_if;
  logic [1:0]  slice;
  logic [2:0]  au_ra_sel;
  logic [31:0] au_ra;
  logic [2:0]  au_rb_sel;
  logic [31:0] au_rb;
  logic        au_rc_vld;
  logic [2:0]  au_rc_sel;
  logic [31:0] au_rc;
  logic        ls_rc_vld;
  logic [1:0]  ls_rc_thread;
  logic [2:0]  ls_rc_sel;
  logic [31:0] ls_rc;
  logic        ld_issue;
  logic [2:0]  ld_sel;
  logic        chk_vld;
  logic        chk_ra;
  logic        chk_rb;
  logic        chk_rd;
  logic [2:0]  chk_rd_sel;
  logic        rf_stall;
  logic [3:0]  rf_pend_any;

  modport master (
    output slice, au_ra_sel, au_rb_sel, au_rc_vld, au_rc_sel, au_rc,
           ls_rc_vld, ls_rc_thread, ls_rc_sel, ls_rc, ld_issue, ld_sel,
           chk_vld, chk_ra, chk_rb, chk_rd, chk_rd_sel,
    input  au_ra, au_rb, rf_stall, rf_pend_any
  );

  modport slave (
    input  slice, au_ra_sel, au_rb_sel, au_rc_vld, au_rc_sel, au_rc,
           ls_rc_vld, ls_rc_thread, ls_rc_sel, ls_rc, ld_issue, ld_sel,
           chk_vld, chk_ra, chk_rb, chk_rd, chk_rd_sel,
    output au_ra, au_rb, rf_stall, rf_pend_any
  );
endinterface

// File: rtl/tawas_regfile.sv
// Tawas per-thread register file (4 threads x 8 x 32b) with AU and LS write
// ports and a pending-load scoreboard. TAWAS_REGFILE_RST_CLEAR_EN puts the array in reset.
module tawas_regfile_bank #(
  parameter logic [31:0] RST_PATTERN = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             au_we,
  input  logic [2:0]       au_sel,
  input  logic [31:0]      au_data,
  input  logic             ls_we,
  input  logic [2:0]       ls_sel,
  input  logic [31:0]      ls_data,
  input  logic             ld_set,
  input  logic [2:0]       ld_sel,
  output logic [7:0][31:0] regs,
  output logic [7:0]       pend
);
  logic [7:0][31:0] regs_nxt;
  logic [7:0]       pend_nxt;

  // LS beats AU on a same-register collision; a new issue beats a return.
  always_comb begin
    regs_nxt = regs;
    pend_nxt = pend;
    for (int i = 0; i < 8; i++) begin
      if (ls_we && ls_sel == 3'(i))
        regs_nxt[i] = ls_data;
      else if (au_we && au_sel == 3'(i))
        regs_nxt[i] = au_data;
      if (ld_set && ld_sel == 3'(i))
        pend_nxt[i] = 1'b1;
      else if (ls_we && ls_sel == 3'(i))
        pend_nxt[i] = 1'b0;
    end
  end

`ifdef TAWAS_REGFILE_RST_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs <= {8{RST_PATTERN}};
    else     regs <= regs_nxt;
  end
`else
  // No reset net on the array so it can map onto plain storage.
  always_ff @(posedge clk) begin
    regs <= regs_nxt;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end
endmodule

module tawas_regfile #(
  parameter int          NTHREAD     = 4,
  parameter logic [31:0] RST_PATTERN = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  tawas_regfile_if.slave rf
);
  logic [1:0]                       wthr;
  logic [NTHREAD-1:0]               au_we;
  logic [NTHREAD-1:0]               ls_we;
  logic [NTHREAD-1:0]               ld_set;
  logic [NTHREAD-1:0][7:0][31:0]    regs_all;
  logic [NTHREAD-1:0][7:0]          pend_all;
  logic [7:0]                       cur_pend;

  // AU results land two slices after the read, so never on the read thread.
  assign wthr = rf.slice + 2'd2;

  for (genvar t = 0; t < NTHREAD; t++) begin : g_bank
    assign au_we[t]  = rf.au_rc_vld && (wthr == 2'(t));
    assign ls_we[t]  = rf.ls_rc_vld && (rf.ls_rc_thread == 2'(t));
    assign ld_set[t] = rf.ld_issue  && (rf.slice == 2'(t));

    tawas_regfile_bank #(.RST_PATTERN(RST_PATTERN)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .au_we   (au_we[t]),
      .au_sel  (rf.au_rc_sel),
      .au_data (rf.au_rc),
      .ls_we   (ls_we[t]),
      .ls_sel  (rf.ls_rc_sel),
      .ls_data (rf.ls_rc),
      .ld_set  (ld_set[t]),
      .ld_sel  (rf.ld_sel),
      .regs    (regs_all[t]),
      .pend    (pend_all[t])
    );

    assign rf.rf_pend_any[t] = |pend_all[t];
  end

  assign rf.au_ra  = regs_all[rf.slice][rf.au_ra_sel];
  assign rf.au_rb  = regs_all[rf.slice][rf.au_rb_sel];
  assign cur_pend  = pend_all[rf.slice];

  assign rf.rf_stall = rf.chk_vld & ((rf.chk_ra & cur_pend[rf.au_ra_sel]) |
                                     (rf.chk_rb & cur_pend[rf.au_rb_sel]) |
                                     (rf.chk_rd & cur_pend[rf.chk_rd_sel]));
endmodule

// File: tb/tb_tawas_regfile.sv
// Directed bench for tawas_regfile: stimulus queues expectations, a negedge
// monitor pops and compares them against the combinational outputs.
module tb_tawas_regfile;
  localparam logic [31:0] RP = 32'hA5A5_5A5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tawas_regfile_if rf ();
  tawas_regfile #(.NTHREAD(4), .RST_PATTERN(RP)) dut (.clk(clk), .rst(rst), .rf(rf));

  typedef struct {
    string       name;
    int          kind;   // 0 au_ra, 1 au_rb, 2 rf_stall, 3 rf_pend_any
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        0:       act = rf.au_ra;
        1:       act = rf.au_rb;
        2:       act = {31'd0, rf.rf_stall};
        default: act = {28'd0, rf.rf_pend_any};
      endcase
      n_chk++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
    end
  end

  task automatic push(input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.name = nm; e.kind = kind; e.exp = v;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rf.au_rc_vld = 0; rf.ls_rc_vld = 0; rf.ld_issue = 0;
    rf.chk_vld = 0; rf.chk_ra = 0; rf.chk_rb = 0; rf.chk_rd = 0;
  endtask

  task automatic ls_wr(input logic [1:0] t, input logic [2:0] s, input logic [31:0] d);
    rf.ls_rc_vld = 1; rf.ls_rc_thread = t; rf.ls_rc_sel = s; rf.ls_rc = d;
  endtask

  task automatic rd_ra(input logic [1:0] sl, input logic [2:0] s, input logic [31:0] v,
                       input string nm);
    idle(); rf.slice = sl; rf.au_ra_sel = s;
    push(0, v, nm); cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rf.slice = 0; rf.au_ra_sel = 0; rf.au_rb_sel = 0; rf.au_rc_sel = 0; rf.au_rc = 0;
    rf.ls_rc_thread = 0; rf.ls_rc_sel = 0; rf.ls_rc = 0; rf.ld_sel = 0; rf.chk_rd_sel = 0;
    idle();
    cyc(); cyc();
    rf.chk_vld = 1; rf.chk_ra = 1; rf.chk_rb = 1; rf.chk_rd = 1;
    push(2, 0, "reset_stall"); push(3, 0, "reset_pend_any");
    cyc(); rst = 0; cyc();
    push(2, 0, "post_reset_stall"); cyc();

`ifdef TAWAS_REGFILE_RST_CLEAR_EN
    for (int s = 0; s < 4; s++)
      for (int r = 0; r < 8; r++) rd_ra(2'(s), 3'(r), RP, "rst_pattern");
`endif

    // Preload r3 of threads 1..3 through the LS port.
    for (int t = 1; t < 4; t++) begin
      idle(); ls_wr(2'(t), 3'd3, 32'h3000_0000 + t); cyc();
    end
    // slice 2 write-back targets thread 0.
    idle(); rf.slice = 2; rf.au_rc_vld = 1; rf.au_rc_sel = 3; rf.au_rc = 32'hDEAD_BEEF; cyc();
    rd_ra(0, 3, 32'hDEAD_BEEF, "au_write_t0_r3");
    rd_ra(1, 3, 32'h3000_0001, "t1_r3_unchanged");
    rd_ra(2, 3, 32'h3000_0002, "t2_r3_unchanged");
    rd_ra(3, 3, 32'h3000_0003, "t3_r3_unchanged");

    // Same thread/reg collision: LS wins. slice 3 -> AU thread 1.
    idle(); rf.slice = 3; rf.au_rc_vld = 1; rf.au_rc_sel = 5; rf.au_rc = 32'h1111;
    ls_wr(1, 5, 32'h2222); cyc();
    idle(); rf.slice = 1; rf.au_rb_sel = 5; push(1, 32'h2222, "collision_ls_wins"); cyc();
    // Different-thread simultaneous writes both land.
    idle(); rf.slice = 3; rf.au_rc_vld = 1; rf.au_rc_sel = 6; rf.au_rc = 32'hAAAA;
    ls_wr(2, 6, 32'hBBBB); cyc();
    rd_ra(1, 6, 32'hAAAA, "dual_write_au");
    rd_ra(2, 6, 32'hBBBB, "dual_write_ls");

    // Scoreboard: load on thread 1 r4.
    idle(); rf.slice = 1; rf.ld_issue = 1; rf.ld_sel = 4; cyc();
    idle(); rf.slice = 1; rf.chk_vld = 1; rf.chk_ra = 1; rf.au_ra_sel = 4;
    push(2, 1, "raw_stall"); push(3, 4'b0010, "pend_any_t1"); cyc();
    ls_wr(1, 4, 32'h55);
    push(2, 1, "stall_held_during_return"); cyc();
    rf.ls_rc_vld = 0;
    push(2, 0, "stall_released"); push(0, 32'h55, "load_data"); push(3, 0, "pend_any_clear"); cyc();

    // WAW on thread 3 r2.
    idle(); rf.slice = 3; rf.ld_issue = 1; rf.ld_sel = 2; cyc();
    idle(); rf.slice = 3; rf.chk_vld = 1; rf.chk_rd = 1; rf.chk_rd_sel = 2;
    rf.chk_ra = 1; rf.au_ra_sel = 0; rf.chk_rb = 1; rf.au_rb_sel = 1;
    push(2, 1, "waw_stall"); cyc();
    rf.chk_rd = 0; push(2, 0, "waw_off_no_stall"); cyc();
    rf.au_rb_sel = 2; push(2, 1, "rb_stall"); cyc();
    rf.chk_vld = 0; push(2, 0, "chk_vld_off"); cyc();

    // Set and clear of thread 0 r7 in one cycle: set wins.
    idle(); rf.slice = 0; rf.ld_issue = 1; rf.ld_sel = 7; cyc();
    idle(); rf.slice = 0; rf.ld_issue = 1; rf.ld_sel = 7; ls_wr(0, 7, 32'h77); cyc();
    idle(); rf.slice = 0; rf.chk_vld = 1; rf.chk_ra = 1; rf.au_ra_sel = 7;
    push(2, 1, "set_beats_clear"); push(0, 32'h77, "return_data_written");
    push(3, 4'b1001, "pend_any_t0_t3"); cyc();

    // Fill all threads, then reset mid-flight.
    idle(); rf.slice = 1; rf.ld_issue = 1; rf.ld_sel = 0; cyc();
    idle(); rf.slice = 2; rf.ld_issue = 1; rf.ld_sel = 1; cyc();
    idle(); rf.slice = 1; rf.chk_vld = 1; rf.chk_ra = 1; rf.au_ra_sel = 0;
    push(3, 4'b1111, "pend_any_all"); push(2, 1, "pre_reset_stall"); cyc();
    rst = 1;
    push(3, 0, "midreset_pend_any"); push(2, 0, "midreset_stall"); cyc();
    rst = 0; idle(); cyc();
`ifdef TAWAS_REGFILE_RST_CLEAR_EN
    for (int s = 0; s < 4; s++)
      for (int r = 0; r < 8; r++) rd_ra(2'(s), 3'(r), RP, "rst_pattern_midflight");
`endif
    // A stale return after reset still writes its register.
    idle(); ls_wr(2, 1, 32'h99); cyc();
    idle(); rf.slice = 2; rf.au_ra_sel = 1; rf.chk_vld = 1; rf.chk_ra = 1;
    push(0, 32'h99, "stale_return_write"); push(2, 0, "stale_return_no_stall");
    push(3, 0, "stale_return_pend_any"); cyc();

    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL queue_drain: %0d left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
